demodchest_burst_sched: RTL and testbench
=========================================

Name: demodchest_burst_sched

Overview:
- Burst scheduler between the demodchest input stream (chdr_to_axis_data output) and the demod/channel-estimation core.
- Host arms a burst over CtrlPort, with an optional start timestamp and a packet count.
- The block drops packets until the start condition is met, then forwards exactly N whole packets and tags the last one with EOB.
- Also reports state and packet/drop counters back over CtrlPort.

Parameters:
- BASE_ADDR, 20'h0, CtrlPort base address; the block decodes offsets 0x00–0x18.
- ITEM_W, 32, data width of the tdata bus.
- CNT_W, 16, width of the packet-count register and counters.

Ports:
- axis_data_clk  in  1  single clock; CtrlPort shares this clock.
- axis_data_rst  in  1  reset, synchronous, active-high.
- s_ctrlport_req_wr / s_ctrlport_req_rd  in  1  CtrlPort write/read strobes.
- s_ctrlport_req_addr  in  20  CtrlPort address.
- s_ctrlport_req_data  in  32  CtrlPort write data.
- s_ctrlport_resp_ack  out  1  CtrlPort response acknowledge.
- s_ctrlport_resp_data  out  32  CtrlPort read data.
- s_in_axis_tdata  in  ITEM_W; s_in_axis_tlast/tvalid  in  1; s_in_axis_tready  out  1.
- s_in_axis_ttimestamp  in  64; s_in_axis_thas_time  in  1; s_in_axis_tlength  in  16; s_in_axis_teov/teob  in  1.
- m_core_axis_*  out (tready in)  same set and widths as s_in_axis_*; output toward the core.
- burst_active  out  1  high in PASS.
- burst_done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Registers (offset from BASE_ADDR):
  - 0x00 CTRL, write-only: bit0 ARM, bit1 ABORT, bit2 TIMED. ARM and ABORT self-clear.
  - 0x04 NUM_PKTS, R/W. 0 means continuous until ABORT.
  - 0x08 START_LO, R/W. 0x0C START_HI, R/W.
  - 0x10 STATUS, RO: [2:0] state, bit4 DONE (sticky, cleared by ARM), bit5 ABORTED (sticky, cleared by ARM).
  - 0x14 PKT_CNT, RO. 0x18 DROP_CNT, RO, saturating.
- CtrlPort responses:
  - ack exactly 1 cycle after any wr/rd, including unmapped addresses.
  - Unmapped reads return 0; resp_data is 0 whenever ack=0.
  - Writes to 0x04–0x0C are ignored outside IDLE.
- Reset values: all registers 0, state IDLE, ack=0, m_core_axis_tvalid=0, s_in_axis_tready=0, burst_active=0, burst_done=0.
- Start-of-packet (SOP) flag: set at reset, set after each accepted tlast beat, cleared on any other accepted beat.
- IDLE:
  - in_tready=0 (backpressure).
  - ARM → WAIT if TIMED=1, else → PASS. ARM also clears PKT_CNT, DROP_CNT, DONE and ABORTED.
  - ARM while not IDLE is ignored.
- WAIT:
  - At an SOP beat, if thas_time=1 and ttimestamp ≥ {START_HI,START_LO} (64-bit unsigned), → PASS without consuming that beat.
  - Otherwise → DROP.
  - ABORT → IDLE, ABORTED=1.
- DROP:
  - in_tready=1; beats are discarded.
  - On the tlast beat: DROP_CNT++, then → WAIT. If ABORT is pending, → IDLE with ABORTED=1 instead.
- PASS:
  - Zero-latency pass-through: m.tvalid = s.tvalid, s.tready = m.tready; all sideband is forwarded.
  - m.teob = s.teob | (tlast & last-packet), where last-packet is (PKT_CNT+1 == NUM_PKTS) or abort pending.
  - On an accepted tlast: PKT_CNT++. If last-packet: → IDLE, burst_done pulse, DONE=1 (plus ABORTED=1 if the exit was an abort).
- ABORT semantics:
  - In PASS or DROP, ABORT is latched as pending and acts at the next packet boundary; packets are never truncated.
  - At SOP in PASS, pending abort → IDLE immediately with ABORTED=1.
- Outside PASS, m_core_axis_tvalid=0.
- Counters saturate at 2^CNT_W−1.
- ARM and ABORT written in the same cycle: ABORT wins and ARM is ignored.
- Reset mid-packet: immediate return to IDLE; downstream must tolerate the truncation.

Decomposition:
- Package demodchest_pkg:
  - register offsets: REG_CTRL, REG_NUM_PKTS, REG_START_LO/HI, REG_STATUS, REG_PKT_CNT, REG_DROP_CNT;
  - CTRL bit positions;
  - state enum: IDLE=0, WAIT=1, DROP=2, PASS=3.
- Sub-module demodchest_sched_regs: CtrlPort decode, register file and the ARM/ABORT pulse generation. The FSM stays in the top-level module.

Test Plan:
- Untimed: NUM_PKTS=3, ARM with TIMED=0, five 8-beat packets supplied → exactly 3 forwarded; teob on beat 24 only; PKT_CNT=3; DONE=1; packets 4–5 held (tready=0).
- Timed: START=1000; packets with timestamps 900, 950, 1000, 1100; NUM_PKTS=2 → DROP_CNT=2; packets at 1000 and 1100 forwarded; burst_done pulses once.
- Abort: abort mid-packet in PASS with NUM_PKTS=0 → current packet completes with teob=1 on tlast; state IDLE; ABORTED=1; no truncation.
- Backpressure: m.tready toggling 50% in PASS → data matches input beat-for-beat; no duplication or loss; zero added latency.
- CtrlPort: read of unmapped 0x40 → ack after 1 cycle, data 0; write to NUM_PKTS during PASS → ignored, readback unchanged.
- Reset: reset asserted mid-PASS → next cycle tvalid=0, tready=0, STATUS=0, PKT_CNT=0.

Source files
------------

// File: rtl/demodchest_pkg.sv
// rtl/demodchest_pkg.sv - shared register map, control bits and state encoding for the burst scheduler
package demodchest_pkg;

  localparam logic [19:0] REG_CTRL     = 20'h00;
  localparam logic [19:0] REG_NUM_PKTS = 20'h04;
  localparam logic [19:0] REG_START_LO = 20'h08;
  localparam logic [19:0] REG_START_HI = 20'h0C;
  localparam logic [19:0] REG_STATUS   = 20'h10;
  localparam logic [19:0] REG_PKT_CNT  = 20'h14;
  localparam logic [19:0] REG_DROP_CNT = 20'h18;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_TIMED     = 2;
  localparam int STATUS_DONE    = 4;
  localparam int STATUS_ABORTED = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    PASS = 2'd3
  } state_t;

endpackage

// File: rtl/demodchest_burst_sched_if.sv
// rtl/demodchest_burst_sched_if.sv - timestamped packet stream carried between demodchest stages
interface demodchest_burst_sched_if #(
  parameter int ITEM_W = 32
);
  logic [ITEM_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic [63:0]       ttimestamp;
  logic              thas_time;
  logic [15:0]       tlength;
  logic              teov;
  logic              teob;

  modport master (
    output tdata, tlast, tvalid, ttimestamp, thas_time, tlength, teov, teob,
    input  tready
  );

  modport slave (
    input  tdata, tlast, tvalid, ttimestamp, thas_time, tlength, teov, teob,
    output tready
  );
endinterface

// File: rtl/demodchest_sched_regs.sv
// rtl/demodchest_sched_regs.sv - CtrlPort decode, burst configuration registers and ARM/ABORT pulses
module demodchest_sched_regs
  import demodchest_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_wr,
  input  logic             req_rd,
  input  logic [19:0]      req_addr,
  input  logic [31:0]      req_data,
  output logic             resp_ack,
  output logic [31:0]      resp_data,
  input  state_t           state,
  input  logic             done,
  input  logic             aborted,
  input  logic [CNT_W-1:0] pkt_cnt,
  input  logic [CNT_W-1:0] drop_cnt,
  output logic             arm,
  output logic             abort,
  output logic             timed,
  output logic [CNT_W-1:0] num_pkts,
  output logic [63:0]      start_time
);

  logic [19:0] offset;
  logic [31:0] rd_val;
  logic [31:0] start_lo;
  logic [31:0] start_hi;

  assign offset     = req_addr - BASE_ADDR;
  assign start_time = {start_hi, start_lo};

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    case (offset)
      REG_NUM_PKTS: rd_val = 32'(num_pkts);
      REG_START_LO: rd_val = start_lo;
      REG_START_HI: rd_val = start_hi;
      REG_STATUS: begin
        rd_val[2:0]            = {1'b0, state};
        rd_val[STATUS_DONE]    = done;
        rd_val[STATUS_ABORTED] = aborted;
      end
      REG_PKT_CNT:  rd_val = 32'(pkt_cnt);
      REG_DROP_CNT: rd_val = 32'(drop_cnt);
      default:      rd_val = '0;
    endcase
  end

  // Register writes, one-cycle ack/response and self-clearing command pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_ack  <= 1'b0;
      resp_data <= '0;
      arm       <= 1'b0;
      abort     <= 1'b0;
      timed     <= 1'b0;
      num_pkts  <= '0;
      start_lo  <= '0;
      start_hi  <= '0;
    end else begin
      resp_ack  <= req_wr | req_rd;
      resp_data <= req_rd ? rd_val : '0;
      arm       <= 1'b0;
      abort     <= 1'b0;
      if (req_wr) begin
        case (offset)
          REG_CTRL: begin
            // ABORT takes priority over a simultaneous ARM.
            abort <= req_data[CTRL_ABORT];
            arm   <= req_data[CTRL_ARM] & ~req_data[CTRL_ABORT];
            if (req_data[CTRL_ARM] && !req_data[CTRL_ABORT] && state == IDLE)
              timed <= req_data[CTRL_TIMED];
          end
          REG_NUM_PKTS: if (state == IDLE) num_pkts <= req_data[CNT_W-1:0];
          REG_START_LO: if (state == IDLE) start_lo <= req_data;
          REG_START_HI: if (state == IDLE) start_hi <= req_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/demodchest_burst_sched.sv
// rtl/demodchest_burst_sched.sv - drops packets until the burst start, then forwards N whole packets tagged with EOB
module demodchest_burst_sched
  import demodchest_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h0,
  parameter int          ITEM_W    = 32,
  parameter int          CNT_W     = 16
) (
  input  logic        axis_data_clk,
  input  logic        axis_data_rst,
  input  logic        s_ctrlport_req_wr,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  input  logic [31:0] s_ctrlport_req_data,
  output logic        s_ctrlport_resp_ack,
  output logic [31:0] s_ctrlport_resp_data,
  demodchest_burst_sched_if.slave  s_in_axis,
  demodchest_burst_sched_if.master m_core_axis,
  output logic        burst_active,
  output logic        burst_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic             sop, abort_pend, done, aborted;
  logic [CNT_W-1:0] pkt_cnt, drop_cnt, num_pkts;
  logic [CNT_W:0]   pkt_plus, drop_plus;
  logic [63:0]      start_time;
  logic             arm, abort, timed;
  logic             abort_any, last_pkt, ts_ok;
  logic             pkt_inc, drop_inc, set_done, set_aborted;

  demodchest_sched_regs #(.BASE_ADDR(BASE_ADDR), .CNT_W(CNT_W)) u_regs (
    .clk        (axis_data_clk),
    .rst        (axis_data_rst),
    .req_wr     (s_ctrlport_req_wr),
    .req_rd     (s_ctrlport_req_rd),
    .req_addr   (s_ctrlport_req_addr),
    .req_data   (s_ctrlport_req_data),
    .resp_ack   (s_ctrlport_resp_ack),
    .resp_data  (s_ctrlport_resp_data),
    .state      (state),
    .done       (done),
    .aborted    (aborted),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .arm        (arm),
    .abort      (abort),
    .timed      (timed),
    .num_pkts   (num_pkts),
    .start_time (start_time)
  );

  // Sideband goes straight through; only tvalid/tready/teob are qualified by state.
  assign m_core_axis.tdata      = s_in_axis.tdata[ITEM_W-1:0];
  assign m_core_axis.tlast      = s_in_axis.tlast;
  assign m_core_axis.ttimestamp = s_in_axis.ttimestamp;
  assign m_core_axis.thas_time  = s_in_axis.thas_time;
  assign m_core_axis.tlength    = s_in_axis.tlength;
  assign m_core_axis.teov       = s_in_axis.teov;

  // Extra top bit of the sums doubles as the saturation flag.
  assign pkt_plus     = {1'b0, pkt_cnt} + {1'b0, CNT_ONE};
  assign drop_plus    = {1'b0, drop_cnt} + {1'b0, CNT_ONE};
  assign abort_any    = abort_pend | abort;
  assign last_pkt     = (pkt_plus == {1'b0, num_pkts}) | abort_any;
  assign ts_ok        = s_in_axis.thas_time & (s_in_axis.ttimestamp >= start_time);
  assign burst_active = (state == PASS);

  // Next-state and stream handshake decode.
  always_comb begin
    state_nx           = state;
    s_in_axis.tready   = 1'b0;
    m_core_axis.tvalid = 1'b0;
    m_core_axis.teob   = s_in_axis.teob;
    pkt_inc            = 1'b0;
    drop_inc           = 1'b0;
    set_done           = 1'b0;
    set_aborted        = 1'b0;
    case (state)
      IDLE: if (arm) state_nx = timed ? WAIT : PASS;
      WAIT: begin
        if (abort) begin
          state_nx    = IDLE;
          set_aborted = 1'b1;
        end else if (s_in_axis.tvalid) begin
          // The qualifying beat is left in place so PASS forwards it.
          state_nx = (sop && ts_ok) ? PASS : DROP;
        end
      end
      DROP: begin
        s_in_axis.tready = 1'b1;
        if (s_in_axis.tvalid && s_in_axis.tlast) begin
          drop_inc = 1'b1;
          if (abort_any) begin
            state_nx    = IDLE;
            set_aborted = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      PASS: begin
        if (sop && abort_any) begin
          state_nx    = IDLE;
          set_aborted = 1'b1;
        end else begin
          m_core_axis.tvalid = s_in_axis.tvalid;
          s_in_axis.tready   = m_core_axis.tready;
          m_core_axis.teob   = s_in_axis.teob | (s_in_axis.tlast & last_pkt);
          if (s_in_axis.tvalid && m_core_axis.tready && s_in_axis.tlast) begin
            pkt_inc = 1'b1;
            if (last_pkt) begin
              state_nx    = IDLE;
              set_done    = 1'b1;
              set_aborted = abort_any;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, packet-boundary tracking, counters and sticky status.
  always_ff @(posedge axis_data_clk) begin
    if (axis_data_rst) begin
      state      <= IDLE;
      sop        <= 1'b1;
      abort_pend <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      burst_done <= set_done;
      abort_pend <= (state_nx != IDLE) && abort_any;
      if (s_in_axis.tvalid && s_in_axis.tready)
        sop <= s_in_axis.tlast;
      if (state == IDLE && arm) begin
        pkt_cnt  <= '0;
        drop_cnt <= '0;
        done     <= 1'b0;
        aborted  <= 1'b0;
      end else begin
        if (pkt_inc && !pkt_plus[CNT_W])   pkt_cnt  <= pkt_plus[CNT_W-1:0];
        if (drop_inc && !drop_plus[CNT_W]) drop_cnt <= drop_plus[CNT_W-1:0];
        if (set_done)    done    <= 1'b1;
        if (set_aborted) aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demodchest_burst_sched.sv
// tb/tb_demodchest_burst_sched.sv - scoreboard bench for the demodchest burst scheduler
module tb_demodchest_burst_sched;
  import demodchest_pkg::*;

  localparam logic [19:0] BASE = 20'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_wr = 1'b0, req_rd = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        burst_active, burst_done;

  demodchest_burst_sched_if #(.ITEM_W(32)) s_if ();
  demodchest_burst_sched_if #(.ITEM_W(32)) m_if ();

  demodchest_burst_sched #(.BASE_ADDR(BASE), .ITEM_W(32), .CNT_W(16)) dut (
    .axis_data_clk        (clk),
    .axis_data_rst        (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .s_in_axis            (s_if),
    .m_core_axis          (m_if),
    .burst_active         (burst_active),
    .burst_done           (burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [63:0] ts;
    logic        has_time;
    logic [15:0] len;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        eob;
    logic [63:0] ts;
  } exp_t;

  beat_t       beats[$];
  exp_t        exp_q[$];
  logic [63:0] pkt_ts[$];
  bit          pkt_ht[$];
  int          pkt_len[$];

  int passed = 0, total = 0;
  int done_pulses = 0, beats_seen = 0;
  bit sb_on = 1'b1, bp_on = 1'b0, pt_chk = 1'b0;
  int cons;
  exp_t e;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endfunction

  // Output-side monitor: scoreboard pops, burst_done pulse count, pass-through check.
  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) begin
      beats_seen++;
      if (sb_on) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("beat", 128'({m_if.tdata, m_if.tlast, m_if.teob, m_if.ttimestamp}),
                      128'({e.data, e.last, e.eob, e.ts}));
        end
      end
    end
    if (burst_done) done_pulses++;
    if (pt_chk && burst_active)
      chk("passthru", 128'({m_if.tvalid, s_if.tready}), 128'({s_if.tvalid, m_if.tready}));
  end

  // Downstream ready: always on, or a fair coin when backpressure is enabled.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic clear_pkts();
    beats.delete(); pkt_ts.delete(); pkt_ht.delete(); pkt_len.delete(); exp_q.delete();
  endtask

  task automatic add_pkt(input logic [63:0] ts, input bit ht, input int len);
    beat_t bt;
    pkt_ts.push_back(ts); pkt_ht.push_back(ht); pkt_len.push_back(len);
    for (int i = 0; i < len; i++) begin
      bt.data = $urandom; bt.last = (i == len - 1); bt.ts = ts;
      bt.has_time = ht; bt.len = 16'(len);
      beats.push_back(bt);
    end
  endtask

  // Reference: skip packets until one starts with a time at/after start, then take num whole packets.
  task automatic run_model(input int num, input bit timed, input logic [63:0] start,
                           output int exp_cons, output int exp_drop, output int exp_fwd);
    int b = 0, fwd = 0, drops = 0;
    bit started = !timed;
    for (int p = 0; p < pkt_len.size(); p++) begin
      if (fwd == num) break;
      if (!started) begin
        if (pkt_ht[p] && pkt_ts[p] >= start) started = 1'b1;
        else begin
          drops++; b += pkt_len[p];
          continue;
        end
      end
      fwd++;
      for (int i = 0; i < pkt_len[p]; i++)
        exp_q.push_back('{beats[b+i].data, (i == pkt_len[p] - 1),
                          ((i == pkt_len[p] - 1) && (fwd == num)), beats[b+i].ts});
      b += pkt_len[p];
    end
    exp_cons = b; exp_drop = drops; exp_fwd = fwd;
  endtask

  task automatic send(input int budget, output int consumed);
    int idx = 0;
    for (int c = 0; c < budget && idx < beats.size(); c++) begin
      s_if.tvalid = 1'b1; s_if.tdata = beats[idx].data; s_if.tlast = beats[idx].last;
      s_if.ttimestamp = beats[idx].ts; s_if.thas_time = beats[idx].has_time;
      s_if.tlength = beats[idx].len;
      @(negedge clk);
      if (s_if.tready) idx++;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    consumed = idx;
  endtask

  task automatic wr(input logic [19:0] off, input logic [31:0] d);
    req_wr = 1'b1; req_addr = BASE + off; req_data = d;
    @(posedge clk); #1;
    req_wr = 1'b0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [19:0] off, input logic [31:0] want);
    req_rd = 1'b1; req_addr = BASE + off;
    @(posedge clk); #1;
    req_rd = 1'b0; req_addr = '0;
    @(negedge clk);
    chk({name, "_ack"}, 128'(resp_ack), 128'(1));
    chk(name, 128'(resp_data), 128'(want));
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input string tag, input int num, input bit timed,
                           input logic [63:0] start, input int budget);
    int exp_cons, exp_drop, exp_fwd, got;
    wr(REG_NUM_PKTS, 32'(num));
    wr(REG_START_LO, start[31:0]);
    wr(REG_START_HI, start[63:32]);
    run_model(num, timed, start, exp_cons, exp_drop, exp_fwd);
    done_pulses = 0;
    wr(REG_CTRL, timed ? 32'h5 : 32'h1);
    send(budget, got);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_consumed"}, 128'(got), 128'(exp_cons));
    rd_chk({tag, "_pkt_cnt"}, REG_PKT_CNT, 32'(exp_fwd));
    rd_chk({tag, "_drop_cnt"}, REG_DROP_CNT, 32'(exp_drop));
    rd_chk({tag, "_status"}, REG_STATUS, 32'h10);
    chk({tag, "_done_pulses"}, 128'(done_pulses), 128'(1));
    chk({tag, "_leftover"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    s_if.tvalid = 1'b1; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.ttimestamp = '0;
    s_if.thas_time = 1'b0; s_if.tlength = '0; s_if.teov = 1'b0; s_if.teob = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with an upstream beat offered to show it is held back.
    @(negedge clk);
    chk("rst_in_tready", 128'(s_if.tready), 128'(0));
    chk("rst_out_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("rst_active", 128'(burst_active), 128'(0));
    chk("rst_done", 128'(burst_done), 128'(0));
    chk("rst_ack", 128'(resp_ack), 128'(0));
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    rd_chk("rst_status", REG_STATUS, 32'h0);
    rd_chk("rst_pkt_cnt", REG_PKT_CNT, 32'h0);
    rd_chk("rst_num_pkts", REG_NUM_PKTS, 32'h0);

    // Untimed: 3 of 5 eight-beat packets forwarded, rest held.
    clear_pkts();
    for (int p = 0; p < 5; p++) add_pkt(64'd0, 1'b0, 8);
    run_burst("untimed", 3, 1'b0, 64'd0, 80);

    // Timed: start 1000, packets at 900/950 dropped.
    clear_pkts();
    add_pkt(64'd900, 1'b1, 4); add_pkt(64'd950, 1'b1, 4);
    add_pkt(64'd1000, 1'b1, 4); add_pkt(64'd1100, 1'b1, 4);
    run_burst("timed", 2, 1'b1, 64'd1000, 80);

    // Randomized timed bursts under 50% downstream backpressure.
    bp_on = 1'b1; pt_chk = 1'b1;
    for (int it = 0; it < 4; it++) begin
      int num, ndrop;
      logic [63:0] start;
      clear_pkts();
      num = int'($urandom_range(1, 3));
      ndrop = int'($urandom_range(0, 2));
      start = 64'($urandom_range(500, 2000));
      for (int p = 0; p < ndrop; p++)
        add_pkt(64'($urandom_range(0, 32'(start) + 500)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 6)));
      for (int p = 0; p < num; p++)
        add_pkt(start + 64'($urandom_range(0, 100)), 1'b1, int'($urandom_range(1, 6)));
      run_burst($sformatf("rand%0d", it), num, 1'b1, start, 400);
    end
    bp_on = 1'b0; pt_chk = 1'b0;
    @(posedge clk); #1;

    // CtrlPort: unmapped read acks one cycle later with zero data.
    req_rd = 1'b1; req_addr = 20'h40;
    @(negedge clk);
    chk("unmapped_ack_early", 128'(resp_ack), 128'(0));
    @(posedge clk); #1;
    req_rd = 1'b0; req_addr = '0;
    @(negedge clk);
    chk("unmapped_ack", 128'(resp_ack), 128'(1));
    chk("unmapped_data", 128'(resp_data), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("unmapped_ack_once", 128'(resp_ack), 128'(0));
    @(posedge clk); #1;
    rd_chk("status_again", REG_STATUS, 32'h10);
    @(negedge clk);
    chk("idle_resp_data", 128'(resp_data), 128'(0));
    @(posedge clk); #1;

    // Abort mid-packet 2 of a continuous burst; NUM_PKTS locked while running.
    clear_pkts();
    for (int p = 0; p < 3; p++) add_pkt(64'd0, 1'b0, 8);
    wr(REG_NUM_PKTS, 32'd0);
    begin
      int ec, ed, ef;
      // The abort lands inside packet 2, so the burst ends exactly as a 2-packet burst would.
      run_model(2, 1'b0, 64'd0, ec, ed, ef);
      done_pulses = 0; beats_seen = 0;
      wr(REG_CTRL, 32'h1);
      fork
        send(80, cons);
        begin
          wr(REG_NUM_PKTS, 32'd5);
          rd_chk("num_locked", REG_NUM_PKTS, 32'd0);
          for (int c = 0; c < 100 && beats_seen < 10; c++) @(negedge clk);
          chk("abort_wait", 128'(beats_seen >= 10), 128'(1));
          @(posedge clk); #1;
          wr(REG_CTRL, 32'h2);
        end
      join
      repeat (2) @(posedge clk);
      #1;
      chk("abort_consumed", 128'(cons), 128'(ec));
      rd_chk("abort_status", REG_STATUS, 32'h30);
      rd_chk("abort_pkt_cnt", REG_PKT_CNT, 32'(ef));
      chk("abort_done_pulses", 128'(done_pulses), 128'(1));
      chk("abort_leftover", 128'(exp_q.size()), 128'(0));
    end

    // Reset in the middle of a passing packet.
    sb_on = 1'b0;
    clear_pkts();
    add_pkt(64'd0, 1'b0, 20);
    beats_seen = 0;
    wr(REG_CTRL, 32'h1);
    fork
      send(40, cons);
      begin
        for (int c = 0; c < 100 && beats_seen < 3; c++) @(negedge clk);
        chk("rst_mid_wait", 128'(beats_seen >= 3), 128'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tvalid", 128'(m_if.tvalid), 128'(0));
        chk("rst_mid_tready", 128'(s_if.tready), 128'(0));
        chk("rst_mid_active", 128'(burst_active), 128'(0));
      end
    join
    rd_chk("rst_mid_status", REG_STATUS, 32'h0);
    rd_chk("rst_mid_pkt_cnt", REG_PKT_CNT, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
